// File: rtl/opcodes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opcodes (package)
// Description : Encodings shared by control_unit, the datapath and the bench:
//               PC source select, instruction groups, ALU function codes,
//               branch condition codes and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package opcodes;

  // PC source select driven to the datapath PC mux
  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_LR     = 2'd2,
    PC_HOLD   = 2'd3
  } pc_select_t;

  // Instruction group, Opcode[7:5]
  localparam logic [2:0] GRP_ALU_R  = 3'd0;
  localparam logic [2:0] GRP_ALU_I  = 3'd1;
  localparam logic [2:0] GRP_LOAD   = 3'd2;
  localparam logic [2:0] GRP_STORE  = 3'd3;
  localparam logic [2:0] GRP_BRANCH = 3'd4;
  localparam logic [2:0] GRP_CALL   = 3'd5;
  localparam logic [2:0] GRP_RET    = 3'd6;
  localparam logic [2:0] GRP_SYS    = 3'd7;

  // ALU function codes, Opcode[4:0] for the ALU groups
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_NOT = 5'd5;
  localparam logic [4:0] ALU_SHL = 5'd6;
  localparam logic [4:0] ALU_SHR = 5'd7;
  localparam logic [4:0] ALU_CMP = 5'd8;
  localparam logic [4:0] ALU_MOV = 5'd9;

  // Branch condition, Opcode[3:0]; codes 11..15 are never taken
  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_CS = 4'd3,
    COND_CC = 4'd4,
    COND_MI = 4'd5,
    COND_PL = 4'd6,
    COND_VS = 4'd7,
    COND_VC = 4'd8,
    COND_GE = 4'd9,
    COND_LT = 4'd10
  } cond_t;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int IDLE_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/control_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational branch-condition evaluator.
// Ports       : flags - {Z,N,C,V}
//               cond  - condition code (cond_t encoding, 11..15 = never)
//               taken - branch condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import opcodes::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       taken
);

  logic z, n, c, v;

  always_comb begin
    {z, n, c, v} = flags;
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle sequencer for the 16-bit core. One instruction in
//               flight: IDLE -> FETCH -> EXEC [-> MEM] -> FETCH, HALT is
//               terminal until reset. All controls are decoded
//               combinationally from the state and Opcode.
// Ports       : Clock, nReset (async, active-low)
//               Opcode[7:0] (group/AluOp/cond), Flags[3:0] {Z,N,C,V}, MemReady
//               AluOp, Op2Sel, Op1Sel, Rw, WdSel, datapath enables, PcSel,
//               Halted
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import opcodes::*;
#(
  parameter int RESET_IDLE_CYCLES = 1
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [7:0] Opcode,
  input  logic [3:0] Flags,
  input  logic       MemReady,
  output logic [4:0] AluOp,
  output logic [1:0] Op2Sel,
  output logic       Op1Sel,
  output logic       Rw,
  output logic       WdSel,
  output logic       AluEn,
  output logic       SpEn,
  output logic       SpWe,
  output logic       LrEn,
  output logic       LrWe,
  output logic       PcWe,
  output logic       PcEn,
  output logic       IrWe,
  output logic       ImmSel,
  output logic       RegWe,
  output logic       MemEn,
  output pc_select_t PcSel,
  output logic       Halted
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(RESET_IDLE_CYCLES - 1);

  state_t                state_q, state_d;
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                  branch_taken;
  logic [2:0]            group;
  logic                  is_load;

  assign group   = Opcode[7:5];
  assign is_load = (group == GRP_LOAD);

  cond_eval u_cond_eval (
    .flags (Flags),
    .cond  (Opcode[3:0]),
    .taken (branch_taken)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    AluOp      = ALU_ADD;
    Op2Sel     = 2'd0;
    Op1Sel     = 1'b0;
    Rw         = 1'b0;
    WdSel      = 1'b0;
    AluEn      = 1'b0;
    SpEn       = 1'b0;
    SpWe       = 1'b0;
    LrEn       = 1'b0;
    LrWe       = 1'b0;
    PcWe       = 1'b0;
    PcEn       = 1'b0;
    IrWe       = 1'b0;
    ImmSel     = 1'b0;
    RegWe      = 1'b0;
    MemEn      = 1'b0;
    PcSel      = PC_INC;
    Halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (idle_cnt_q == IDLE_LAST) begin
          state_d = S_FETCH;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      S_FETCH: begin
        PcEn  = 1'b1;
        MemEn = 1'b1;
        Rw    = 1'b1;
        if (MemReady) begin
          IrWe    = 1'b1;
          PcWe    = 1'b1;
          PcSel   = PC_INC;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (group)
          GRP_ALU_R, GRP_ALU_I: begin
            AluOp  = Opcode[4:0];
            Op2Sel = (group == GRP_ALU_I) ? 2'd1 : 2'd0;
            AluEn  = 1'b1;
            RegWe  = (Opcode[4:0] != ALU_CMP);
          end
          GRP_LOAD, GRP_STORE: begin
            // Effective address setup; the access itself happens in S_MEM
            AluOp   = ALU_ADD;
            Op2Sel  = 2'd1;
            state_d = S_MEM;
          end
          GRP_BRANCH, GRP_CALL: begin
            // CALL is unconditional; BRANCH follows the evaluated condition
            if (group == GRP_CALL || branch_taken) begin
              Op1Sel = 1'b1;
              Op2Sel = 2'd1;
              ImmSel = 1'b1;
              AluOp  = ALU_ADD;
              AluEn  = 1'b1;
              PcSel  = PC_BRANCH;
              PcWe   = 1'b1;
            end
            LrWe = (group == GRP_CALL);
          end
          GRP_RET: begin
            LrEn  = 1'b1;
            PcSel = PC_LR;
            PcWe  = 1'b1;
          end
          default: begin
            if (Opcode[0]) begin
              state_d = S_HALT;
            end
          end
        endcase
      end

      S_MEM: begin
        AluOp  = ALU_ADD;
        Op2Sel = 2'd1;
        AluEn  = 1'b1;
        MemEn  = 1'b1;
        Rw     = is_load;
        WdSel  = is_load;
        RegWe  = is_load & MemReady;
        if (MemReady) begin
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        Halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Self-checking bench for control_unit. Instruction vectors are
//               run through fetch/exec/mem; the expected control word of each
//               cycle is queued when the cycle is driven and checked when the
//               outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;
  import opcodes::*;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [1:0] op2;
    logic       op1, rw, wd, alu_en, sp_en, sp_we, lr_en, lr_we;
    logic       pc_we, pc_en, ir_we, imm_sel, reg_we, mem_en;
    logic [1:0] pc_sel;
    logic       halted;
  } ctrl_t;

  typedef struct {
    logic [7:0] op;
    logic [3:0] flags;
    int         fwait;
    ctrl_t      exec_exp;
    logic       is_mem;
    logic       is_load;
    int         mwait;
  } vec_t;

  logic       Clock, nReset, MemReady;
  logic [7:0] Opcode;
  logic [3:0] Flags;
  logic [4:0] AluOp;
  logic [1:0] Op2Sel;
  logic       Op1Sel, Rw, WdSel, AluEn, SpEn, SpWe, LrEn, LrWe;
  logic       PcWe, PcEn, IrWe, ImmSel, RegWe, MemEn, Halted;
  pc_select_t PcSel;
  logic       ref_taken;

  ctrl_t act;
  ctrl_t sb_q[$];
  vec_t  vecs[$];
  int    total = 0;
  int    bad   = 0;

  control_unit #(.RESET_IDLE_CYCLES(1)) dut (
    .Clock(Clock), .nReset(nReset), .Opcode(Opcode), .Flags(Flags),
    .MemReady(MemReady), .AluOp(AluOp), .Op2Sel(Op2Sel), .Op1Sel(Op1Sel),
    .Rw(Rw), .WdSel(WdSel), .AluEn(AluEn), .SpEn(SpEn), .SpWe(SpWe),
    .LrEn(LrEn), .LrWe(LrWe), .PcWe(PcWe), .PcEn(PcEn), .IrWe(IrWe),
    .ImmSel(ImmSel), .RegWe(RegWe), .MemEn(MemEn), .PcSel(PcSel),
    .Halted(Halted)
  );

  cond_eval u_ref (.flags(Flags), .cond(Opcode[3:0]), .taken(ref_taken));

  assign act = {AluOp, Op2Sel, Op1Sel, Rw, WdSel, AluEn, SpEn, SpWe, LrEn,
                LrWe, PcWe, PcEn, IrWe, ImmSel, RegWe, MemEn, 2'(PcSel), Halted};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- expected control words ----------------
  function automatic ctrl_t fetch_exp(input logic ready);
    ctrl_t c = '0;
    c.pc_en = 1; c.mem_en = 1; c.rw = 1;
    c.ir_we = ready; c.pc_we = ready;
    return c;
  endfunction

  function automatic ctrl_t alu_exp(input logic [4:0] f, input logic imm);
    ctrl_t c = '0;
    c.alu_op = f; c.op2 = imm ? 2'd1 : 2'd0; c.alu_en = 1;
    c.reg_we = (f != 5'd8);
    return c;
  endfunction

  function automatic ctrl_t ls_exp();
    ctrl_t c = '0;
    c.op2 = 2'd1;
    return c;
  endfunction

  function automatic ctrl_t br_exp(input logic taken, input logic call);
    ctrl_t c = '0;
    if (taken) begin
      c.op1 = 1; c.op2 = 2'd1; c.imm_sel = 1; c.alu_en = 1;
      c.pc_sel = 2'd1; c.pc_we = 1;
    end
    c.lr_we = call;
    return c;
  endfunction

  function automatic ctrl_t ret_exp();
    ctrl_t c = '0;
    c.lr_en = 1; c.pc_sel = 2'd2; c.pc_we = 1;
    return c;
  endfunction

  function automatic ctrl_t mem_exp(input logic load, input logic ready);
    ctrl_t c = '0;
    c.op2 = 2'd1; c.alu_en = 1; c.mem_en = 1;
    c.rw = load; c.wd = load; c.reg_we = load & ready;
    return c;
  endfunction

  function automatic ctrl_t halt_exp();
    ctrl_t c = '0;
    c.halted = 1;
    return c;
  endfunction

  // Flags = {Z,N,C,V}
  function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
    logic z, n, c, v;
    z = f[3]; n = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'd0:    return 1'b1;
      4'd1:    return z;
      4'd2:    return !z;
      4'd3:    return c;
      4'd4:    return !c;
      4'd5:    return n;
      4'd6:    return !n;
      4'd7:    return v;
      4'd8:    return !v;
      4'd9:    return n ~^ v;
      4'd10:   return n ^ v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [7:0] op, input logic [3:0] fl, input int fw,
                              input ctrl_t e, input logic m, input logic ld, input int mw);
    vec_t r;
    r.op = op; r.flags = fl; r.fwait = fw; r.exec_exp = e;
    r.is_mem = m; r.is_load = ld; r.mwait = mw;
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string nm, input ctrl_t got, input ctrl_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // One clock cycle: queue the expectation, sample at the falling edge,
  // then return 1 time unit after the next rising edge.
  task automatic step(input string nm, input ctrl_t e);
    ctrl_t want;
    sb_q.push_back(e);
    @(negedge Clock);
    want = sb_q.pop_front();
    check(nm, act, want);
    @(posedge Clock);
    #1;
  endtask

  task automatic run_instr(input string nm, input vec_t v);
    MemReady = 1'b0;
    for (int i = 0; i < v.fwait; i++) step({nm, "_fwait"}, fetch_exp(1'b0));
    MemReady = 1'b1;
    step({nm, "_fetch"}, fetch_exp(1'b1));
    Opcode   = v.op;
    Flags    = v.flags;
    MemReady = 1'($urandom);
    step({nm, "_exec"}, v.exec_exp);
    if (v.is_mem) begin
      MemReady = 1'b0;
      for (int i = 0; i < v.mwait; i++) step({nm, "_mwait"}, mem_exp(v.is_load, 1'b0));
      MemReady = 1'b1;
      step({nm, "_mem"}, mem_exp(v.is_load, 1'b1));
    end
  endtask

  initial begin
    nReset = 1'b0; MemReady = 1'b0; Opcode = 8'h00; Flags = 4'h0;

    // Vector table: {opcode, flags, fetch waits, exec word, mem?, load?, mem waits}
    vecs.push_back(mk(8'h00, 4'h0, 0, alu_exp(ALU_ADD, 0), 0, 0, 0));
    vecs.push_back(mk({3'b000, ALU_CMP}, 4'h0, 0, alu_exp(ALU_CMP, 0), 0, 0, 0));
    vecs.push_back(mk({3'b001, ALU_SUB}, 4'h0, 2, alu_exp(ALU_SUB, 1), 0, 0, 0));
    vecs.push_back(mk({3'b001, ALU_CMP}, 4'h0, 0, alu_exp(ALU_CMP, 1), 0, 0, 0));
    vecs.push_back(mk({3'b000, ALU_XOR}, 4'hF, 0, alu_exp(ALU_XOR, 0), 0, 0, 0));
    vecs.push_back(mk(8'h40, 4'h0, 0, ls_exp(), 1, 1, 3));
    vecs.push_back(mk(8'h40, 4'h0, 0, ls_exp(), 1, 1, 0));
    vecs.push_back(mk(8'h60, 4'h0, 0, ls_exp(), 1, 0, 0));
    vecs.push_back(mk(8'h60, 4'h0, 1, ls_exp(), 1, 0, 2));
    vecs.push_back(mk(8'h81, 4'b1000, 0, br_exp(1, 0), 0, 0, 0));
    vecs.push_back(mk(8'h81, 4'b0000, 0, br_exp(0, 0), 0, 0, 0));
    vecs.push_back(mk(8'h89, 4'b0000, 0, br_exp(1, 0), 0, 0, 0));
    vecs.push_back(mk(8'h89, 4'b0001, 0, br_exp(0, 0), 0, 0, 0));
    vecs.push_back(mk(8'h89, 4'b0100, 0, br_exp(0, 0), 0, 0, 0));
    vecs.push_back(mk(8'h89, 4'b0101, 0, br_exp(1, 0), 0, 0, 0));
    vecs.push_back(mk(8'h8A, 4'b0000, 0, br_exp(0, 0), 0, 0, 0));
    vecs.push_back(mk(8'h8A, 4'b0001, 0, br_exp(1, 0), 0, 0, 0));
    vecs.push_back(mk(8'h8A, 4'b0100, 0, br_exp(1, 0), 0, 0, 0));
    vecs.push_back(mk(8'h8A, 4'b0101, 0, br_exp(0, 0), 0, 0, 0));
    vecs.push_back(mk(8'h8F, 4'b1111, 0, br_exp(0, 0), 0, 0, 0));
    vecs.push_back(mk(8'hA0, 4'h0, 0, br_exp(1, 1), 0, 0, 0));
    vecs.push_back(mk(8'hC0, 4'h0, 0, ret_exp(), 0, 0, 0));
    vecs.push_back(mk(8'hE0, 4'h0, 0, ctrl_t'(0), 0, 0, 0));

    // Reset state
    #2;
    check("reset_outputs", act, ctrl_t'(0));
    repeat (2) @(posedge Clock);
    #1;
    nReset = 1'b1;
    MemReady = 1'b1;
    step("idle", ctrl_t'(0));

    foreach (vecs[i]) run_instr($sformatf("v%0d", i), vecs[i]);

    // Sweep all condition codes against all flag patterns
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        run_instr($sformatf("br_c%0d_f%0d", c, f),
                  mk({4'b1000, 4'(c)}, 4'(f), 0, br_exp(cond_ref(4'(c), 4'(f)), 0), 0, 0, 0));
        total++;
        if (ref_taken !== cond_ref(4'(c), 4'(f))) begin
          bad++;
          $display("FAIL cond_eval_c%0d_f%0d: got=%b want=%b", c, f, ref_taken, cond_ref(4'(c), 4'(f)));
        end
      end
    end

    // HALT: terminal until reset regardless of inputs
    run_instr("halt", mk(8'hE1, 4'h0, 0, ctrl_t'(0), 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      MemReady = 1'($urandom);
      Opcode   = 8'($urandom);
      Flags    = 4'($urandom);
      step("halted", halt_exp());
    end

    // Reset while halted, then a load with reset asserted mid-S_MEM
    nReset = 1'b0;
    #1;
    check("rst_from_halt", act, ctrl_t'(0));
    @(posedge Clock);
    #1;
    nReset = 1'b1;
    step("idle2", ctrl_t'(0));
    MemReady = 1'b1;
    step("ld_fetch", fetch_exp(1'b1));
    Opcode = 8'h40;
    step("ld_exec", ls_exp());
    MemReady = 1'b0;
    step("ld_mwait", mem_exp(1'b1, 1'b0));
    #2;
    check("ld_mem_pre_rst", act, mem_exp(1'b1, 1'b0));
    nReset = 1'b0;
    #1;
    check("rst_async_mid_mem", act, ctrl_t'(0));
    @(posedge Clock);
    #1;
    MemReady = 1'b1;
    step("rst_held", ctrl_t'(0));
    nReset = 1'b1;
    step("idle3", ctrl_t'(0));
    run_instr("post_rst", mk({3'b000, ALU_OR}, 4'h0, 0, alu_exp(ALU_OR, 0), 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Sequencing FSM directly upstream of `datapath`.
- Consumes `Opcode`/`Flags` from the datapath and a memory-ready strobe.
- Drives every datapath control line: fetch, execute and memory cycles for the 16-bit core.
- One instruction in flight; multi-cycle, no pipelining.

Parameters:
- RESET_IDLE_CYCLES, 1, cycles spent in S_IDLE after nReset release before first fetch (1..15).

Ports:
- Clock  input  1  system clock, rising edge
- nReset  input  1  asynchronous active-low reset
- Opcode  input  8  IR[15:8] from datapath; [7:5] group, [4:0] AluOp or condition
- Flags  input  4  {Z,N,C,V} = Flags[3:0], registered by datapath
- MemReady  input  1  memory completes access this cycle
- AluOp  output  5  ALU function
- Op2Sel  output  2  0=Rb, 1=Imm, 2=PC
- Op1Sel  output  1  0=Ra, 1=PC
- Rw  output  1  1=read, 0=write
- WdSel  output  1  register write data: 0=ALU, 1=DataIn
- AluEn, SpEn, SpWe, LrEn, LrWe, PcWe, PcEn, IrWe, ImmSel, RegWe, MemEn  output  1 each  datapath enables
- PcSel  output  pc_select_t  PC source
- Halted  output  1  high in S_HALT

Behaviour:
- Clock is `Clock`. Reset is asynchronous, active-low, on `nReset`.
- Reset: state=S_IDLE, idle counter=0. All outputs 0; PcSel=PC_INC; Halted=0.
- Outputs are combinational from state and Opcode. Opcode is stable from the cycle after IrWe.
- Any output not listed for a state is 0.
- SpEn/SpWe are held 0 in this revision.
- S_IDLE: count to RESET_IDLE_CYCLES, then go to S_FETCH.
- S_FETCH: PcEn=1, MemEn=1, Rw=1.
  - If MemReady=1: IrWe=1, PcWe=1, PcSel=PC_INC, then S_EXEC.
  - If MemReady=0: IrWe=PcWe=0; stay in S_FETCH. Wait is unbounded.
- S_EXEC by group Opcode[7:5]:
  - 000 ALU reg: AluOp=Opcode[4:0], Op2Sel=0, AluEn=1, WdSel=0. RegWe=1 unless AluOp==ALU_CMP. Next S_FETCH.
  - 001 ALU imm: as 000 with Op2Sel=1, ImmSel=0.
  - 010 LOAD / 011 STORE: address setup. AluOp=ALU_ADD, Op2Sel=1, ImmSel=0. Next S_MEM.
  - 100 BRANCH: cond=Opcode[3:0].
    - Codes: 0 AL, 1 EQ(Z), 2 NE, 3 CS(C), 4 CC, 5 MI(N), 6 PL, 7 VS(V), 8 VC, 9 GE(N==V), 10 LT(N!=V). 11-15 never.
    - Taken: Op1Sel=1, Op2Sel=1, ImmSel=1, AluOp=ALU_ADD, AluEn=1, PcSel=PC_BRANCH, PcWe=1.
    - Next S_FETCH.
  - 101 CALL: LrWe=1 (LR<=PC) plus taken-branch controls. Next S_FETCH.
  - 110 RET: LrEn=1, PcSel=PC_LR, PcWe=1. Next S_FETCH.
  - 111 SYS: Opcode[0]=1 → HALT, next S_HALT; otherwise NOP, next S_FETCH.
- S_MEM:
  - AluOp=ALU_ADD, Op2Sel=1, AluEn=1 (address on SysBus), MemEn=1, Rw = 1 for LOAD / 0 for STORE.
  - LOAD: WdSel=1, RegWe=MemReady.
  - Leave to S_FETCH only when MemReady=1.
- S_HALT: all outputs 0, Halted=1. Exit only via nReset.
- Latency:
  - ALU/branch/call/ret/nop: 2 cycles.
  - Load/store: 3 cycles.
  - Each MemReady=0 cycle adds 1.
- Flags are sampled in S_EXEC only; flags written by the previous instruction are already registered.
- Reset mid-access: outputs 0 immediately (asynchronous); the partial access is abandoned.

Decomposition:
- Package opcodes holds the following, shared with the datapath and bench:
  - pc_select_t {PC_INC=0, PC_BRANCH=1, PC_LR=2, PC_HOLD=3}
  - group constants GRP_ALU_R…GRP_SYS
  - ALU_ADD, ALU_CMP and the other ALU codes
  - cond_t codes
  - state_t {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT}
- One sub-module: cond_eval (combinational Flags×cond → taken), reused by the bench's model.

Test Plan:
- Reset then MemReady=1 → S_IDLE 1 cycle, then FETCH cycle with PcEn=MemEn=Rw=IrWe=PcWe=1, PcSel=PC_INC.
- Opcode=8'b000_00000 (ALU reg ADD) → EXEC: AluEn=1, RegWe=1, WdSel=0, AluOp=0. Repeat with AluOp=ALU_CMP → RegWe=0.
- LOAD (8'h40), MemReady low 3 cycles in S_MEM → S_MEM held 3 cycles with RegWe=0, then RegWe=1, WdSel=1 for one cycle, then FETCH. STORE (8'h60) → Rw=0 in S_MEM.
- BRANCH EQ (8'h81) with Flags=4'b1000 → PcWe=1, PcSel=PC_BRANCH. With Flags=4'b0000 → PcWe=0. Cover conds 9/10 with N/V combinations 00, 01, 10, 11.
- CALL (8'hA0) → LrWe=1 and PcWe=1 in same cycle. RET (8'hC0) → LrEn=1, PcSel=PC_LR.
- HALT (8'hE1) → Halted=1, all controls 0 for 20 cycles. nReset asserted mid-S_MEM → outputs 0 before the next Clock edge.
